retire_monitor: RTL and testbench

RETIRE_MONITOR -- requirements
Module: retire_monitor

---
 rtl/retire_monitor.sv | 99 +++++++++
 tb/tb_retire_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/retire_monitor.sv
// Retirement monitor: tracks run state, cycle/retire counts and a writeback signature,
// ending the run on the halt PC or after TIMEOUT consecutive non-retiring cycles.
module retire_monitor #(
    parameter logic [31:0] HALT_PC = 32'h00000118,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validW,
    input  logic [31:0] pcW,
    input  logic        regwriteW,
    input  logic [4:0]  rdW,
    input  logic [31:0] wdW,
    output logic [1:0]  state,
    output logic        done,
    output logic        hung,
    output logic        end_pulse,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt,
    output logic [31:0] sig,
    output logic [31:0] last_pc
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10,
        StHung = 2'b11
    } state_e;

    localparam logic [31:0] IdleLimit = 32'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        end_q, end_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] retire_q, retire_d;
    logic [31:0] sig_q, sig_d;
    logic [31:0] last_pc_q, last_pc_d;
    logic [31:0] idle_q, idle_d;

    always_comb begin
        state_d   = state_q;
        end_d     = 1'b0;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        sig_d     = sig_q;
        last_pc_d = last_pc_q;
        idle_d    = idle_q;

        if (state_q == StIdle || state_q == StRun) begin
            cycle_d = (cycle_q == 32'hFFFFFFFF) ? cycle_q : cycle_q + 32'd1;
            // pcW/rdW/wdW are only looked at under validW so X inputs cannot leak out
            if (validW) begin
                idle_d    = 32'd0;
                retire_d  = (retire_q == 32'hFFFFFFFF) ? retire_q : retire_q + 32'd1;
                last_pc_d = pcW;
                if (regwriteW && rdW != 5'd0) begin
                    sig_d = {sig_q[30:0], sig_q[31]} ^ wdW ^ {27'b0, rdW};
                end
                state_d = (pcW == HALT_PC) ? StDone : StRun;
            end else if (idle_q == IdleLimit) begin
                state_d = StHung;
            end else begin
                idle_d = idle_q + 32'd1;
            end
            end_d = (state_d == StDone) || (state_d == StHung);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            end_q     <= 1'b0;
            cycle_q   <= 32'd0;
            retire_q  <= 32'd0;
            sig_q     <= 32'd0;
            last_pc_q <= 32'd0;
            idle_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            end_q     <= end_d;
            cycle_q   <= cycle_d;
            retire_q  <= retire_d;
            sig_q     <= sig_d;
            last_pc_q <= last_pc_d;
            idle_q    <= idle_d;
        end
    end

    assign state      = state_q;
    assign done       = (state_q == StDone);
    assign hung       = (state_q == StHung);
    assign end_pulse  = end_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
    assign sig        = sig_q;
    assign last_pc    = last_pc_q;

endmodule

// File: tb/tb_retire_monitor.sv
// Directed bench for retire_monitor with a short timeout so hang paths are reachable quickly.
module tb_retire_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        validW;
    logic [31:0] pcW;
    logic        regwriteW;
    logic [4:0]  rdW;
    logic [31:0] wdW;
    logic [1:0]  state;
    logic        done;
    logic        hung;
    logic        end_pulse;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;
    logic [31:0] sig;
    logic [31:0] last_pc;

    int checks   = 0;
    int failures = 0;

    retire_monitor #(
        .HALT_PC(32'h00000118),
        .TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .validW    (validW),
        .pcW       (pcW),
        .regwriteW (regwriteW),
        .rdW       (rdW),
        .wdW       (wdW),
        .state     (state),
        .done      (done),
        .hung      (hung),
        .end_pulse (end_pulse),
        .cycle_cnt (cycle_cnt),
        .retire_cnt(retire_cnt),
        .sig       (sig),
        .last_pc   (last_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [1:0]  e_state;
        logic [31:0] e_cycle;
        logic [31:0] e_retire;
        logic [31:0] e_sig;
        logic [31:0] e_last;
        logic        e_end;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] e_state,
                           input logic [31:0] e_cycle, input logic [31:0] e_retire,
                           input logic [31:0] e_sig, input logic [31:0] e_last,
                           input logic e_end);
        chk({name, ".state"}, {30'b0, state}, {30'b0, e_state});
        chk({name, ".done"}, {31'b0, done}, {31'b0, e_state == 2'b10});
        chk({name, ".hung"}, {31'b0, hung}, {31'b0, e_state == 2'b11});
        chk({name, ".end_pulse"}, {31'b0, end_pulse}, {31'b0, e_end});
        chk({name, ".cycle_cnt"}, cycle_cnt, e_cycle);
        chk({name, ".retire_cnt"}, retire_cnt, e_retire);
        chk({name, ".sig"}, sig, e_sig);
        chk({name, ".last_pc"}, last_pc, e_last);
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic rw,
                        input logic [4:0] rd, input logic [31:0] wd);
        validW    = v;
        pcW       = pc;
        regwriteW = rw;
        rdW       = rd;
        wdW       = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    endtask

    task automatic do_reset(input string name);
        reset     = 1'b1;
        validW    = 1'b0;
        pcW       = 32'h0;
        regwriteW = 1'b0;
        rdW       = 5'd0;
        wdW       = 32'h0;
        @(posedge clk);
        #1;
        chk_all(name, 2'b00, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Halting program with signature updates; last row checks DONE is frozen.
        //          v   pc         rw  rd  wd              state cyc ret sig     last       end
        vecs[0] = '{1, 32'h000, 1, 5'd1, 32'h5,        2'b01, 1, 1, 32'h4,  32'h000, 0};
        vecs[1] = '{1, 32'h004, 1, 5'd2, 32'h3,        2'b01, 2, 2, 32'h9,  32'h004, 0};
        vecs[2] = '{1, 32'h008, 1, 5'd0, 32'hFFFFFFFF, 2'b01, 3, 3, 32'h9,  32'h008, 0};
        vecs[3] = '{1, 32'h00C, 0, 5'd5, 32'h1234,     2'b01, 4, 4, 32'h9,  32'h00C, 0};
        vecs[4] = '{1, 32'h118, 1, 5'd3, 32'h10,       2'b10, 5, 5, 32'h1,  32'h118, 1};
        vecs[5] = '{1, 32'h200, 1, 5'd1, 32'hFF,       2'b10, 5, 5, 32'h1,  32'h118, 0};

        do_reset("reset0");
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].v, vecs[i].pc, vecs[i].rw, vecs[i].rd, vecs[i].wd);
            chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_cycle,
                    vecs[i].e_retire, vecs[i].e_sig, vecs[i].e_last, vecs[i].e_end);
        end

        // One retirement then silence: HUNG on the 8th idle cycle, counters frozen after.
        do_reset("reset1");
        step(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
        idle_steps(7);
        chk_all("hang_pre", 2'b01, 8, 1, 0, 0, 1'b0);
        idle_steps(1);
        chk_all("hang_hit", 2'b11, 9, 1, 0, 0, 1'b1);
        step(1'b1, 32'h118, 1'b1, 5'd1, 32'h77);
        chk_all("hang_hold", 2'b11, 9, 1, 0, 0, 1'b0);

        // Halt retirement in the timeout cycle wins over the hang.
        do_reset("reset2");
        idle_steps(7);
        chk_all("coinc_pre", 2'b00, 7, 0, 0, 0, 1'b0);
        step(1'b1, 32'h118, 1'b0, 5'd0, 32'h0);
        chk_all("coinc_done", 2'b10, 8, 1, 0, 32'h118, 1'b1);

        // A non-halt retirement in the timeout cycle restarts the idle count.
        do_reset("reset3");
        idle_steps(7);
        step(1'b1, 32'h40, 1'b0, 5'd0, 32'h0);
        chk_all("rescue", 2'b01, 8, 1, 0, 32'h40, 1'b0);
        idle_steps(7);
        chk_all("rescue_idle", 2'b01, 15, 1, 0, 32'h40, 1'b0);
        idle_steps(1);
        chk_all("rescue_hang", 2'b11, 16, 1, 0, 32'h40, 1'b1);

        // Asynchronous reset between edges mid-run.
        do_reset("reset4");
        step(1'b1, 32'h0, 1'b1, 5'd1, 32'h5);
        step(1'b1, 32'h4, 1'b0, 5'd0, 32'h0);
        chk_all("pre_abort", 2'b01, 2, 2, 32'h4, 32'h4, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk_all("async_abort", 2'b00, 0, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        chk_all("abort_hold", 2'b00, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 32'h8, 1'b0, 5'd0, 32'h0);
        chk_all("restart", 2'b01, 1, 1, 0, 32'h8, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
